// File: rtl/chorus_pkg.sv
// Shared constants, FSM encoding and delay helpers for the chorus controller.
package chorus_pkg;

  localparam int unsigned DEF_MEM_WIDTH = 16;
  localparam int unsigned DEF_MEM_DEPTH = 16;
  localparam int unsigned DEF_RD_LAT    = 2;

  // Largest delay a buffer of 2^depth words can express.
  function automatic int unsigned eff_delay_sat(int unsigned depth);
    return (32'd1 << depth) - 32'd1;
  endfunction

  localparam int unsigned EFF_DELAY_SAT = eff_delay_sat(DEF_MEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    MIX   = 3'd3,
    OUT   = 3'd4
  } state_e;

endpackage

// File: rtl/chorus_if.sv
// Sample stream, control, status and delay-buffer port signals of the chorus controller.
interface chorus_if
  import chorus_pkg::*;
#(
  parameter int unsigned MEM_WIDTH = DEF_MEM_WIDTH,
  parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH
) ();

  logic signed [MEM_WIDTH-1:0] sample_in;
  logic                        sample_valid;
  logic                        enable;
  logic [MEM_DEPTH-1:0]        base_delay;
  logic [MEM_DEPTH-1:0]        mod_depth;
  logic [15:0]                 lfo_rate;
  logic                        wea;
  logic [MEM_DEPTH-1:0]        addra;
  logic [MEM_WIDTH-1:0]        dina;
  logic [MEM_DEPTH-1:0]        addrb;
  logic [MEM_WIDTH-1:0]        doutb;
  logic signed [MEM_WIDTH-1:0] sample_out;
  logic                        out_valid;
  logic                        busy;
  logic                        overrun;

  modport master (
    output sample_in, sample_valid, enable, base_delay, mod_depth, lfo_rate, doutb,
    input  wea, addra, dina, addrb, sample_out, out_valid, busy, overrun
  );

  modport slave (
    input  sample_in, sample_valid, enable, base_delay, mod_depth, lfo_rate, doutb,
    output wea, addra, dina, addrb, sample_out, out_valid, busy, overrun
  );

endinterface

// File: rtl/chorus_lfo.sv
// Triangle LFO stepping once per lfo_rate accepted samples between 0 and mod_depth.
module chorus_lfo
  import chorus_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 step_en,
  input  logic [MEM_DEPTH-1:0] mod_depth,
  input  logic [15:0]          lfo_rate,
  output logic [MEM_DEPTH-1:0] lfo_val
);

  logic [15:0]          samp_cnt_q, samp_cnt_d;
  logic [MEM_DEPTH-1:0] lfo_q, lfo_d;
  logic                 dir_up_q, dir_up_d;
  logic                 wrap;

  always_comb begin
    samp_cnt_d = samp_cnt_q;
    lfo_d      = lfo_q;
    dir_up_d   = dir_up_q;
    wrap       = 1'b0;
    if (step_en && (lfo_rate != 16'd0)) begin
      // >= keeps the counter from running away if lfo_rate shrinks below it
      if (samp_cnt_q >= (lfo_rate - 16'd1)) begin
        wrap       = 1'b1;
        samp_cnt_d = 16'd0;
      end else begin
        samp_cnt_d = samp_cnt_q + 16'd1;
      end
      if (mod_depth == '0) begin
        lfo_d    = '0;
        dir_up_d = 1'b1;
      end else if (lfo_q > mod_depth) begin
        lfo_d    = mod_depth;
        dir_up_d = 1'b0;
      end else if (wrap) begin
        if (dir_up_q) begin
          if (lfo_q == mod_depth) begin
            lfo_d    = lfo_q - MEM_DEPTH'(1);
            dir_up_d = 1'b0;
          end else begin
            lfo_d = lfo_q + MEM_DEPTH'(1);
          end
        end else begin
          if (lfo_q == '0) begin
            lfo_d    = lfo_q + MEM_DEPTH'(1);
            dir_up_d = 1'b1;
          end else begin
            lfo_d = lfo_q - MEM_DEPTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      samp_cnt_q <= 16'd0;
      lfo_q      <= '0;
      dir_up_q   <= 1'b1;
    end else begin
      samp_cnt_q <= samp_cnt_d;
      lfo_q      <= lfo_d;
      dir_up_q   <= dir_up_d;
    end
  end

  assign lfo_val = lfo_q;

endmodule

// File: rtl/chorus_controller.sv
// Chorus effect sequencer: writes each dry sample to the delay buffer, reads the
// modulated tap back after RD_LAT cycles and emits the averaged (or bypassed) sample.
module chorus_controller
  import chorus_pkg::*;
#(
  parameter int unsigned MEM_WIDTH = DEF_MEM_WIDTH,
  parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int unsigned RD_LAT    = DEF_RD_LAT
) (
  input  logic    clk,
  input  logic    reset,
  chorus_if.slave bus
);

  localparam int unsigned          WAIT_W  = 8;
  localparam logic [MEM_DEPTH-1:0] DLY_SAT = MEM_DEPTH'(eff_delay_sat(MEM_DEPTH));

  state_e                      state_q, state_d;
  logic [WAIT_W-1:0]           wait_q, wait_d;
  logic [MEM_DEPTH-1:0]        wr_ptr_q, wr_ptr_d;
  logic [MEM_DEPTH-1:0]        fill_q, fill_d;
  logic [MEM_DEPTH-1:0]        addra_q, addra_d;
  logic [MEM_DEPTH-1:0]        addrb_q, addrb_d;
  logic signed [MEM_WIDTH-1:0] dry_q, dry_d;
  logic [MEM_WIDTH-1:0]        dina_q, dina_d;
  logic [MEM_WIDTH-1:0]        sample_out_q, sample_out_d;
  logic                        mix_en_q, mix_en_d;
  logic                        prime_q, prime_d;
  logic                        wea_q, wea_d;
  logic                        out_valid_q, out_valid_d;
  logic                        busy_q, busy_d;
  logic                        overrun_q, overrun_d;

  logic                        accept_c;
  logic [MEM_DEPTH-1:0]        lfo_val;
  logic [MEM_DEPTH:0]          dly_sum_c;
  logic [MEM_DEPTH-1:0]        eff_delay_c;
  logic [MEM_WIDTH-1:0]        wet_c;
  logic signed [MEM_WIDTH:0]   mix_sum_c;

  assign accept_c = (state_q == IDLE) && bus.sample_valid;

  chorus_lfo #(.MEM_DEPTH(MEM_DEPTH)) u_lfo (
    .clk       (clk),
    .reset     (reset),
    .step_en   (accept_c),
    .mod_depth (bus.mod_depth),
    .lfo_rate  (bus.lfo_rate),
    .lfo_val   (lfo_val)
  );

  // Effective delay saturates at the buffer size and never drops to 0 (read == write).
  always_comb begin
    dly_sum_c   = {1'b0, bus.base_delay} + {1'b0, lfo_val};
    eff_delay_c = dly_sum_c[MEM_DEPTH] ? DLY_SAT : dly_sum_c[MEM_DEPTH-1:0];
    if (eff_delay_c == '0) eff_delay_c = MEM_DEPTH'(1);
  end

  // Wet tap is muted while the buffer is not yet filled up to the delay.
  always_comb begin
    wet_c     = prime_q ? '0 : bus.doutb;
    mix_sum_c = $signed({dry_q[MEM_WIDTH-1], dry_q}) + $signed({wet_c[MEM_WIDTH-1], wet_c});
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_q;
    addra_d      = addra_q;
    addrb_d      = addrb_q;
    dry_d        = dry_q;
    dina_d       = dina_q;
    sample_out_d = sample_out_q;
    mix_en_d     = mix_en_q;
    prime_d      = prime_q;
    wea_d        = 1'b0;
    out_valid_d  = 1'b0;
    overrun_d    = overrun_q | (bus.sample_valid && (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (bus.sample_valid) begin
          state_d  = ISSUE;
          dry_d    = bus.sample_in;
          mix_en_d = bus.enable;
          prime_d  = (fill_q < eff_delay_c);
          if (fill_q != DLY_SAT) fill_d = fill_q + MEM_DEPTH'(1);
          wea_d    = 1'b1;
          addra_d  = wr_ptr_q;
          dina_d   = bus.sample_in;
          addrb_d  = wr_ptr_q - eff_delay_c;
        end
      end
      ISSUE: begin
        wr_ptr_d = wr_ptr_q + MEM_DEPTH'(1);
        wait_d   = '0;
        state_d  = (RD_LAT > 1) ? WAIT : MIX;
      end
      WAIT: begin
        wait_d = wait_q + WAIT_W'(1);
        if (wait_q == WAIT_W'(RD_LAT - 2)) state_d = MIX;
      end
      MIX: begin
        sample_out_d = mix_en_q ? mix_sum_c[MEM_WIDTH:1] : dry_q;
        out_valid_d  = 1'b1;
        state_d      = OUT;
      end
      OUT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      addra_q      <= '0;
      addrb_q      <= '0;
      dry_q        <= '0;
      dina_q       <= '0;
      sample_out_q <= '0;
      mix_en_q     <= 1'b0;
      prime_q      <= 1'b0;
      wea_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      addra_q      <= addra_d;
      addrb_q      <= addrb_d;
      dry_q        <= dry_d;
      dina_q       <= dina_d;
      sample_out_q <= sample_out_d;
      mix_en_q     <= mix_en_d;
      prime_q      <= prime_d;
      wea_q        <= wea_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.wea        = wea_q;
  assign bus.addra      = addra_q;
  assign bus.dina       = dina_q;
  assign bus.addrb      = addrb_q;
  assign bus.sample_out = sample_out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_chorus_controller.sv
// Directed bench for chorus_controller: full-size instance plus a 16-word instance
// used to reach pointer wrap-around in a few cycles.
module tb_chorus_controller;
  import chorus_pkg::*;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  chorus_if #(.MEM_WIDTH(16), .MEM_DEPTH(16)) bus ();
  chorus_if #(.MEM_WIDTH(16), .MEM_DEPTH(4))  wb  ();

  chorus_controller #(.MEM_WIDTH(16), .MEM_DEPTH(16), .RD_LAT(2)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  chorus_controller #(.MEM_WIDTH(16), .MEM_DEPTH(4), .RD_LAT(2)) dut_w (
    .clk(clk), .reset(reset), .bus(wb));

  localparam int unsigned LFO_N = 18;
  localparam int unsigned MODS  [LFO_N] = '{2,2,2,2,2,2,1,1,1,1,1,0,0,2,2,2,2,2};
  localparam int unsigned RATES [LFO_N] = '{1,1,1,1,1,1,1,1,1,0,0,1,1,2,2,2,2,2};
  localparam int unsigned EFFS  [LFO_N] = '{10,11,12,11,10,11,12,11,10,11,11,11,10,10,10,11,11,12};

  logic [15:0] mem   [65536];
  logic [15:0] mem_w [16];
  logic [15:0] rd1, rd1_w;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-cycle read-latency buffer models, read-before-write.
  always @(posedge clk) begin
    if (bus.wea) mem[bus.addra] <= bus.dina;
    rd1       <= mem[bus.addrb];
    bus.doutb <= rd1;
    if (wb.wea) mem_w[wb.addra] <= wb.dina;
    rd1_w    <= mem_w[wb.addrb];
    wb.doutb <= rd1_w;
  end

  task automatic do_reset;
    reset = 1'b1;
    bus.sample_valid = 1'b0;
    wb.sample_valid  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic xact(input logic [15:0] s, input bit flip, output logic w,
                      output logic [15:0] a, output logic [15:0] d, output logic [15:0] b,
                      output logic bz, output logic [15:0] o, output int lat);
    bus.sample_in    = s;
    bus.sample_valid = 1'b1;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    if (flip) begin
      bus.enable     = ~bus.enable;
      bus.base_delay = bus.base_delay + 16'd5;
    end
    w = bus.wea; a = bus.addra; d = bus.dina; b = bus.addrb; bz = bus.busy;
    o = '0; lat = 0;
    for (int i = 2; i < 12 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin o = bus.sample_out; lat = i; end
    end
    @(posedge clk); #1;
  endtask

  task automatic wsend(input logic [15:0] s, output logic [3:0] a, output logic [3:0] b,
                       output logic [15:0] o, output int lat);
    wb.sample_in    = s;
    wb.sample_valid = 1'b1;
    @(posedge clk); #1;
    wb.sample_valid = 1'b0;
    a = wb.addra; b = wb.addrb; o = '0; lat = 0;
    for (int i = 2; i < 12 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (wb.out_valid) begin o = wb.sample_out; lat = i; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.wea, bus.out_valid, bus.busy, bus.overrun} !== 4'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", {bus.wea, bus.out_valid, bus.busy, bus.overrun});
    end
    total++;
    if ({bus.addra, bus.dina, bus.addrb, bus.sample_out} !== 64'd0) begin
      bad++; $display("FAIL reset_buses: got %h want 0", {bus.addra, bus.dina, bus.addrb, bus.sample_out});
    end
    reset = 1'b0;
  endtask

  task automatic test_single;
    logic w, bz; logic [15:0] a, d, b, o; int lat;
    do_reset();
    bus.base_delay = 16'd4; bus.mod_depth = 16'd0; bus.lfo_rate = 16'd0; bus.enable = 1'b1;
    xact(16'h1000, 1'b0, w, a, d, b, bz, o, lat);
    total++; if (w !== 1'b1) begin bad++; $display("FAIL single_wea: got %b want 1", w); end
    total++; if (a !== 16'h0000) begin bad++; $display("FAIL single_addra: got %h want 0000", a); end
    total++; if (d !== 16'h1000) begin bad++; $display("FAIL single_dina: got %h want 1000", d); end
    total++; if (b !== 16'hFFFC) begin bad++; $display("FAIL single_addrb: got %h want fffc", b); end
    total++; if (bz !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", bz); end
    total++; if (lat !== 4) begin bad++; $display("FAIL single_latency: got %0d want 4", lat); end
    total++; if (o !== 16'h0800) begin bad++; $display("FAIL single_out: got %h want 0800", o); end
    total++;
    if ({bus.out_valid, bus.wea, bus.busy} !== 3'b000) begin
      bad++; $display("FAIL single_idle: got %b want 000", {bus.out_valid, bus.wea, bus.busy});
    end
  endtask

  task automatic test_primed;
    logic w, bz; logic [15:0] a, d, b, o, eo, eb; int lat;
    do_reset();
    bus.base_delay = 16'd4; bus.mod_depth = 16'd0; bus.lfo_rate = 16'd0; bus.enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      eo = (k == 4) ? 16'h2000 : 16'h1000;
      eb = 16'(k - 4);
      xact((k < 5) ? 16'h2000 : 16'h0000, 1'b0, w, a, d, b, bz, o, lat);
      total++; if (o !== eo) begin bad++; $display("FAIL primed_out[%0d]: got %h want %h", k, o, eo); end
      total++; if (b !== eb) begin bad++; $display("FAIL primed_addrb[%0d]: got %h want %h", k, b, eb); end
    end
  endtask

  task automatic test_signed_mix;
    logic w, bz; logic [15:0] a, d, b, o; int lat;
    logic [15:0] vin [3];
    logic [15:0] vex [3];
    vin = '{16'h4000, 16'h8000, 16'h8000};
    vex = '{16'h2000, 16'hE000, 16'h8000};
    do_reset();
    bus.base_delay = 16'd1; bus.mod_depth = 16'd0; bus.lfo_rate = 16'd0; bus.enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      xact(vin[k], 1'b0, w, a, d, b, bz, o, lat);
      total++; if (o !== vex[k]) begin bad++; $display("FAIL signed_out[%0d]: got %h want %h", k, o, vex[k]); end
    end
  endtask

  task automatic test_lfo;
    logic w, bz; logic [15:0] a, d, b, o, eb; int lat;
    do_reset();
    bus.base_delay = 16'd10; bus.enable = 1'b1;
    for (int k = 0; k < int'(LFO_N); k++) begin
      bus.mod_depth = 16'(MODS[k]);
      bus.lfo_rate  = 16'(RATES[k]);
      eb = 16'(k) - 16'(EFFS[k]);
      xact(16'h0123, 1'b0, w, a, d, b, bz, o, lat);
      total++;
      if (b !== eb) begin bad++; $display("FAIL lfo_addrb[%0d]: got %h want %h (eff %0d)", k, b, eb, EFFS[k]); end
    end
  endtask

  task automatic test_saturation;
    logic w, bz; logic [15:0] a, d, b, o, eb; int lat;
    do_reset();
    bus.base_delay = 16'hFFFF; bus.mod_depth = 16'd1; bus.lfo_rate = 16'd1; bus.enable = 1'b1;
    for (int k = 0; k < 2; k++) begin
      eb = 16'(k) - 16'(EFF_DELAY_SAT);
      xact(16'h0100, 1'b0, w, a, d, b, bz, o, lat);
      total++; if (b !== eb) begin bad++; $display("FAIL sat_addrb[%0d]: got %h want %h", k, b, eb); end
    end
    bus.base_delay = 16'd0; bus.mod_depth = 16'd0;
    xact(16'h0400, 1'b0, w, a, d, b, bz, o, lat);
    total++; if (b !== 16'h0001) begin bad++; $display("FAIL min_addrb[2]: got %h want 0001", b); end
    xact(16'h0200, 1'b0, w, a, d, b, bz, o, lat);
    total++; if (b !== 16'h0002) begin bad++; $display("FAIL min_addrb[3]: got %h want 0002", b); end
    total++; if (o !== 16'h0300) begin bad++; $display("FAIL min_out: got %h want 0300", o); end
  endtask

  task automatic test_overrun;
    logic w, bz; logic [15:0] a, d, b, o; int lat; int pulses;
    do_reset();
    bus.base_delay = 16'd4; bus.mod_depth = 16'd0; bus.lfo_rate = 16'd0; bus.enable = 1'b1;
    bus.sample_in = 16'h0100; bus.sample_valid = 1'b1;
    @(posedge clk); #1 bus.sample_valid = 1'b0;
    @(posedge clk); #1 bus.sample_valid = 1'b1;
    @(posedge clk); #1 bus.sample_valid = 1'b0;
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL overrun_set: got %b want 1", bus.overrun); end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) pulses++;
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL overrun_outputs: got %0d want 1", pulses); end
    xact(16'h0200, 1'b0, w, a, d, b, bz, o, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL overrun_next_latency: got %0d want 4", lat); end
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky: got %b want 1", bus.overrun); end
    do_reset();
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL overrun_clear: got %b want 0", bus.overrun); end
  endtask

  task automatic test_bypass;
    logic w, bz; logic [15:0] a, d, b, o; int lat;
    do_reset();
    bus.base_delay = 16'd4; bus.mod_depth = 16'd0; bus.lfo_rate = 16'd0; bus.enable = 1'b0;
    xact(16'h7FFF, 1'b1, w, a, d, b, bz, o, lat);
    total++; if (o !== 16'h7FFF) begin bad++; $display("FAIL bypass_out: got %h want 7fff", o); end
    total++; if (b !== 16'hFFFC) begin bad++; $display("FAIL bypass_addrb: got %h want fffc", b); end
    bus.base_delay = 16'd4;
    xact(16'h7FFF, 1'b0, w, a, d, b, bz, o, lat);
    total++; if (o !== 16'h3FFF) begin bad++; $display("FAIL reenable_out: got %h want 3fff", o); end
  endtask

  task automatic test_reset_mid;
    int seen;
    do_reset();
    bus.base_delay = 16'd4; bus.enable = 1'b1;
    bus.sample_in = 16'h1234; bus.sample_valid = 1'b1;
    @(posedge clk); #1 bus.sample_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({bus.wea, bus.out_valid, bus.busy, bus.overrun} !== 4'b0) begin
      bad++; $display("FAIL midreset_flags: got %b want 0000", {bus.wea, bus.out_valid, bus.busy, bus.overrun});
    end
    total++;
    if ({bus.addra, bus.dina, bus.addrb, bus.sample_out} !== 64'd0) begin
      bad++; $display("FAIL midreset_buses: got %h want 0", {bus.addra, bus.dina, bus.addrb, bus.sample_out});
    end
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid || bus.wea) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midreset_activity: got %0d want 0", seen); end
  endtask

  task automatic test_wrap;
    logic [3:0] a, b; logic [15:0] o; int lat;
    do_reset();
    wb.base_delay = 4'd3; wb.mod_depth = 4'd0; wb.lfo_rate = 16'd0; wb.enable = 1'b1;
    for (int k = 0; k < 17; k++) begin
      wsend(16'(16'h0100 * (k + 1)), a, b, o, lat);
      if (k == 15) begin
        total++; if (a !== 4'hF) begin bad++; $display("FAIL wrap_addra_last: got %h want f", a); end
        total++; if (b !== 4'hC) begin bad++; $display("FAIL wrap_addrb_last: got %h want c", b); end
      end
    end
    total++; if (a !== 4'h0) begin bad++; $display("FAIL wrap_addra_first: got %h want 0", a); end
    total++; if (b !== 4'hD) begin bad++; $display("FAIL wrap_addrb_first: got %h want d", b); end
    total++; if (o !== 16'h0F80) begin bad++; $display("FAIL wrap_out: got %h want 0f80", o); end
  endtask

  initial begin
    reset = 1'b1;
    bus.sample_in = '0; bus.sample_valid = 1'b0; bus.enable = 1'b0;
    bus.base_delay = '0; bus.mod_depth = '0; bus.lfo_rate = '0;
    wb.sample_in = '0; wb.sample_valid = 1'b0; wb.enable = 1'b0;
    wb.base_delay = '0; wb.mod_depth = '0; wb.lfo_rate = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 16; i++) mem_w[i] = 16'h0000;
    test_reset();
    test_single();
    test_primed();
    test_signed_mix();
    test_lfo();
    test_saturation();
    test_overrun();
    test_bypass();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
